// File: rtl/uart_mem_cmd_decoder_pkg.sv
// rtl/uart_mem_cmd_decoder_pkg.sv - shared state encoding, frame layout and response byte helper
package uart_mem_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT_RD = 3'd4,
    S_SEND    = 3'd5,
    S_ACK     = 3'd6
  } state_e;

  // Header byte bit positions
  localparam int HDR_RW  = 7;
  localparam int HDR_MEM = 6;
  localparam int HDR_A8  = 0;

  // Frame lengths in bytes
  localparam int WR_DATA_BYTES = 4;
  localparam int RESP_BYTES    = 6;

  // Read response word layout: {mem_type, addr[8:0], data[31:0]}
  localparam int RESP_W        = 42;
  localparam int RESP_MEM_BIT  = 41;
  localparam int RESP_ADDR_LSB = 32;
  localparam int RESP_DATA_LSB = 0;

  // Byte idx (0 = first on the wire) of the response word zero-extended to 48 bits
  function automatic logic [7:0] resp_byte(input logic [RESP_W-1:0] word, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {6'b0, word[RESP_MEM_BIT], word[RESP_ADDR_LSB + 8]};
      3'd1:    b = word[RESP_ADDR_LSB +: 8];
      3'd2:    b = word[RESP_DATA_LSB + 24 +: 8];
      3'd3:    b = word[RESP_DATA_LSB + 16 +: 8];
      3'd4:    b = word[RESP_DATA_LSB + 8 +: 8];
      3'd5:    b = word[RESP_DATA_LSB +: 8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// rtl/cmd_timeout_counter.sv - idle-cycle counter that flags expiry after TIMEOUT_CYCLES
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = enable && (count_q == LIMIT);

  // Count enabled cycles, saturating at the limit; clear wins over counting
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_mem_cmd_decoder.sv
// rtl/uart_mem_cmd_decoder.sv - UART byte frames to memory debug commands, read data back to UART
module uart_mem_cmd_decoder
  import uart_mem_cmd_decoder_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] ACK_BYTE       = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic               enable,
  output logic               write_mem_req,
  output logic               target_mem_type,
  output logic [8:0]         target_addr,
  output logic [31:0]        uart_rx_data_in,
  output logic               rw_flag,
  input  logic               data_mem_tx_data_ready,
  input  logic [RESP_W-1:0]  data_mem_tx_data,
  input  logic               inst_mem_tx_data_ready,
  input  logic [RESP_W-1:0]  inst_mem_tx_data,
  output logic               busy,
  output logic               cmd_error
);

  state_e              state_q;
  logic                rw_q;
  logic                mem_q;
  logic [8:0]          addr_q;
  logic [31:0]         data_q;
  logic [1:0]          byte_cnt_q;
  logic [2:0]          send_idx_q;
  logic [RESP_W-1:0]   resp_q;
  logic [7:0]          tx_byte_q;
  logic                tx_valid_q;
  logic                wr_req_q;
  logic                err_q;

  logic                in_rx_frame;
  logic                tmr_enable;
  logic                tmr_clear;
  logic                tmr_expired;
  logic                resp_hit;
  logic [RESP_W-1:0]   resp_word;
  logic                drop_byte;

  // The timer only runs while waiting on the host (mid-frame) or on the selected memory
  assign in_rx_frame = (state_q == S_ADDR) || (state_q == S_DATA);
  assign tmr_enable  = in_rx_frame || (state_q == S_WAIT_RD);
  assign tmr_clear   = !tmr_enable || (in_rx_frame && rx_valid);

  // Only the memory that was addressed may answer; the other strobe is ignored
  assign resp_hit  = mem_q ? inst_mem_tx_data_ready : data_mem_tx_data_ready;
  assign resp_word = mem_q ? inst_mem_tx_data : data_mem_tx_data;

  // Bytes arriving once the frame is complete cannot be buffered and are dropped
  assign drop_byte = rx_valid && ((state_q == S_ISSUE) || (state_q == S_WAIT_RD) ||
                                  (state_q == S_SEND)  || (state_q == S_ACK));

  cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Command FSM: frame assembly, halted issue, response capture and serialisation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      mem_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      send_idx_q <= '0;
      resp_q     <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_req_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_req_q <= 1'b0;
      err_q    <= drop_byte;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            rw_q      <= rx_byte[HDR_RW];
            mem_q     <= rx_byte[HDR_MEM];
            addr_q[8] <= rx_byte[HDR_A8];
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q[7:0] <= rx_byte;
            byte_cnt_q  <= '0;
            state_q     <= rw_q ? S_DATA : S_ISSUE;
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            data_q     <= {data_q[23:0], rx_byte};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'(WR_DATA_BYTES - 1)) begin
              state_q <= S_ISSUE;
            end
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (!enable) begin
            wr_req_q <= 1'b1;
            if (rw_q) begin
              tx_byte_q  <= ACK_BYTE;
              tx_valid_q <= 1'b1;
              state_q    <= S_ACK;
            end else begin
              state_q <= S_WAIT_RD;
            end
          end
        end
        S_WAIT_RD: begin
          if (resp_hit) begin
            resp_q     <= resp_word;
            tx_byte_q  <= resp_byte(resp_word, 3'd0);
            tx_valid_q <= 1'b1;
            send_idx_q <= '0;
            state_q    <= S_SEND;
          end else if (tmr_expired) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (send_idx_q == 3'(RESP_BYTES - 1)) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              send_idx_q <= send_idx_q + 3'd1;
              tx_byte_q  <= resp_byte(resp_q, send_idx_q + 3'd1);
            end
          end
        end
        S_ACK: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign cmd_error       = err_q;
  assign write_mem_req   = wr_req_q;
  assign rw_flag         = rw_q;
  assign target_mem_type = mem_q;
  assign target_addr     = addr_q;
  assign uart_rx_data_in = data_q;
  assign tx_byte         = tx_byte_q;
  assign tx_valid        = tx_valid_q;

endmodule
